// File: rtl/bst_game_ctrl_if.sv
// Signal bundle between the BST game controller and its switch/key front end
// and display stage.
interface bst_game_ctrl_if;
   logic [2:0] sw_index;
   logic       sw_valid;
   logic       key_n;
   logic [2:0] state;
   logic [2:0] target_idx;
   logic [6:0] target_key;
   logic [2:0] exp_node;
   logic [1:0] lives;
   logic [6:0] score;
   logic       hit_pulse;
   logic       miss_pulse;
   logic       invalid_pulse;

   modport master (
      output sw_index, sw_valid, key_n,
      input  state, target_idx, target_key, exp_node, lives, score,
             hit_pulse, miss_pulse, invalid_pulse
   );

   modport slave (
      input  sw_index, sw_valid, key_n,
      output state, target_idx, target_key, exp_node, lives, score,
             hit_pulse, miss_pulse, invalid_pulse
   );
endinterface

// File: rtl/bst_game_ctrl.sv
// BST mini-game controller: key debounce, target generator and the search/score FSM.
//
// state     | meaning
// S_IDLE    | waiting for a press to start a game
// S_PLAY    | checking each confirmed pick against the search path
// S_WIN     | round won, holding feedback for FB_CYCLES
// S_OVER    | no lives left, waiting for a press to return to idle
module bst_game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int FB_CYCLES       = 25000000,
   parameter int LIVES           = 3
) (
   input logic            clk,
   input logic            rst_n,
   bst_game_ctrl_if.slave bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FB_W = $clog2(FB_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PLAY = 3'd1,
      S_WIN  = 3'd2,
      S_OVER = 3'd3
   } state_t;

   function automatic logic [6:0] key_of(input logic [2:0] idx);
      case (idx)
         3'd0:    key_of = 7'd40;
         3'd1:    key_of = 7'd20;
         3'd2:    key_of = 7'd60;
         3'd3:    key_of = 7'd10;
         3'd4:    key_of = 7'd30;
         3'd5:    key_of = 7'd50;
         default: key_of = 7'd70;
      endcase
   endfunction

   logic            sync1, sync2, db_level, press;
   logic [DB_W-1:0] db_cnt;
   logic [2:0]      tgt_cnt;

   state_t          state_q, state_d;
   logic [2:0]      target_q, target_d, exp_q, exp_d;
   logic [1:0]      lives_q, lives_d;
   logic [6:0]      score_q, score_d;
   logic [FB_W-1:0] fb_q, fb_d;
   logic            hit_q, hit_d, miss_q, miss_d, inv_q, inv_d;

   // press fires only when the debounced level settles low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         db_level <= 1'b1;
         db_cnt   <= '0;
         press    <= 1'b0;
         tgt_cnt  <= 3'd0;
      end else begin
         sync1   <= bus.key_n;
         sync2   <= sync1;
         press   <= 1'b0;
         tgt_cnt <= (tgt_cnt == 3'd6) ? 3'd0 : tgt_cnt + 3'd1;
         if (sync2 == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= sync2;
            db_cnt   <= '0;
            press    <= ~sync2;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         target_q <= 3'd0;
         exp_q    <= 3'd0;
         lives_q  <= 2'd0;
         score_q  <= 7'd0;
         fb_q     <= '0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         exp_q    <= exp_d;
         lives_q  <= lives_d;
         score_q  <= score_d;
         fb_q     <= fb_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
         inv_q    <= inv_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      exp_d    = exp_q;
      lives_d  = lives_q;
      score_d  = score_q;
      fb_d     = fb_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      inv_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press) begin
               target_d = tgt_cnt;
               exp_d    = 3'd0;
               lives_d  = 2'(LIVES);
               score_d  = 7'd0;
               state_d  = S_PLAY;
            end
         end
         S_PLAY: begin
            if (press) begin
               if (!bus.sw_valid) begin
                  inv_d = 1'b1;
               end else if (bus.sw_index == exp_q) begin
                  hit_d = 1'b1;
                  if (exp_q == target_q) begin
                     if (score_q < 7'd99) score_d = score_q + 7'd1;
                     fb_d    = FB_W'(FB_CYCLES - 1);
                     state_d = S_WIN;
                  end else if (key_of(target_q) < key_of(exp_q)) begin
                     exp_d = {exp_q[1:0], 1'b1};
                  end else begin
                     exp_d = {exp_q[1:0], 1'b0} + 3'd2;
                  end
               end else begin
                  miss_d  = 1'b1;
                  lives_d = lives_q - 2'd1;
                  if (lives_q == 2'd1) state_d = S_OVER;
               end
            end
         end
         S_WIN: begin
            if (fb_q == '0) begin
               target_d = tgt_cnt;
               exp_d    = 3'd0;
               state_d  = S_PLAY;
            end else begin
               fb_d = fb_q - FB_W'(1);
            end
         end
         S_OVER: begin
            if (press) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.state         = state_q;
   assign bus.target_idx    = target_q;
   assign bus.target_key    = key_of(target_q);
   assign bus.exp_node      = exp_q;
   assign bus.lives         = lives_q;
   assign bus.score         = score_q;
   assign bus.hit_pulse     = hit_q;
   assign bus.miss_pulse    = miss_q;
   assign bus.invalid_pulse = inv_q;
endmodule

// File: doc/bst_game_ctrl.md
# bst_game_ctrl

Game controller for the BST mini-game. It consumes the one-hot switch decode (`sw_index`/`sw_valid`) and a debounced confirm pushbutton. It then walks the player through a search in a fixed 7-node BST, checking each confirmed pick against the correct search path, and keeps target, lives and score for the display stage downstream.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles needed to accept a key level change (bench uses 4).
- `FB_CYCLES`, default 25000000: length of the ROUND_WIN display hold (bench uses 8).
- `LIVES`, default 3: lives loaded at game start, range 1..3.
- `clk  in  1`: system clock. One clock domain only.
- `rst_n  in  1`: reset, synchronous, active-low.
- `sw_index  in  3`: selected node index 0..6 from the switch decoder.
- `sw_valid  in  1`: exactly one legal switch is on.
- `key_n  in  1`: confirm pushbutton, active-low, asynchronous to `clk`.
- `state  out  3`: IDLE=0, PLAY=1, ROUND_WIN=2, OVER=3.
- `target_idx  out  3`: node index of the current target.
- `target_key  out  7`: key stored at `target_idx`.
- `exp_node  out  3`: node the player must pick next.
- `lives  out  2`: remaining lives.
- `score  out  7`: rounds won, saturates at 99.
- `hit_pulse`, `miss_pulse`, `invalid_pulse`  out  1 each: one-cycle feedback strobes.

## Operation
- Tree keys are fixed, stored in level order. Index 0..6 holds 40, 20, 60, 10, 30, 50, 70. Node i has children 2i+1 and 2i+2.
- Key input path:
  - `key_n` passes through a 2-FF synchronizer.
  - The debounce counter resets on every mismatch between the synchronized level and the debounced level.
  - The debounced level toggles when the counter reaches `DEBOUNCE_CYCLES`.
  - `press` is a one-cycle strobe on the debounced 1→0 transition only.
- Target generator: `tgt_cnt` is a free-running 0..6 counter, wrapping 6→0 and advancing every cycle in every state.
- IDLE: on `press`, do all of the following, then go to PLAY:
  - set `target_idx` to `tgt_cnt`
  - set `exp_node` to 0
  - set `lives` to `LIVES`
  - set `score` to 0
- PLAY: on `press`, exactly one of these cases applies:
  - `sw_valid`=0: pulse `invalid_pulse`. No other change.
  - `sw_index`==`exp_node` and `exp_node`==`target_idx`: pulse `hit_pulse`, increment `score` (saturating at 99), go to ROUND_WIN.
  - `sw_index`==`exp_node`, not the target: pulse `hit_pulse`. `exp_node` moves to 2e+1 if key[target] < key[e], else to 2e+2.
  - Wrong node: pulse `miss_pulse`, decrement `lives`. If `lives` becomes 0, go to OVER. `exp_node` is unchanged.
- ROUND_WIN: count `FB_CYCLES` cycles; presses are ignored. On expiry, set `target_idx` to `tgt_cnt`, set `exp_node` to 0, go to PLAY.
- OVER: outputs hold their values. On `press`, go to IDLE; `score` is kept until the next start.
- `sw_index` and `sw_valid` are sampled only in the `press` cycle. Switch changes at any other time have no effect.

## Timing
- Reset values:
  - `state`=IDLE
  - `target_idx`=0, `target_key`=40
  - `exp_node`=0
  - `lives`=0, `score`=0
  - all pulses 0
  - `tgt_cnt`=0
  - debounced level=1, debounce counter=0, synchronizer FFs=1
- Reset taken mid-game or mid-ROUND_WIN returns to these values on the next edge. No state survives reset.
- Press latency: if `key_n` falls before edge N and stays low, the synchronized level is low after edge N+1. `press` is high during the cycle after edge N+1+`DEBOUNCE_CYCLES`.
- Decision latency: outputs and the pulses are registered on the edge that ends the `press` cycle. They are visible one cycle after `press`, and each pulse lasts exactly one cycle.
- A bounce shorter than `DEBOUNCE_CYCLES` yields no `press`. Holding the key yields one `press`; release yields none.
- `target_key` is combinational from `target_idx` via the key ROM.
- ROUND_WIN lasts exactly `FB_CYCLES` cycles from the entry edge to the exit edge.
- A hit on the target and score saturation in the same press: `score` stays 99 and ROUND_WIN is still entered.
- Last life lost: `lives`=0 and `state`=OVER are set on the same edge.

## Test plan
- Reset, then hold `key_n` low for 10 cycles (`DEBOUNCE_CYCLES`=4) → one `press` → PLAY, `exp_node`=0, `lives`=3, `score`=0. `target_idx` equals the bench model of `tgt_cnt`.
- Target 4 (key 30): picks 0, 1, 4 → three `hit_pulse`, `exp_node` goes 0→1→4, then `score`=1, ROUND_WIN for 8 cycles, back to PLAY with `exp_node`=0.
- Target 6: picks 0, 1, 3, 5 → `exp_node` becomes 2, then three `miss_pulse` bringing `lives` 3→2→1→0, with OVER on the third miss.
- `sw_valid`=0 during a press → `invalid_pulse` only; `lives`, `exp_node` and `score` are unchanged.
- `key_n` glitches low for 3 cycles, repeatedly → no `press` and no state change. `sw_index` toggles between presses → no effect.
- Assert `rst_n`=0 for 1 cycle during ROUND_WIN → next cycle all outputs at their reset values and `state`=IDLE.
